// File: rtl/gc_stream_collector_if.sv
// Stream bundle between the garbler, the collector and the host link.
// The garbler side carries tagged beats; the host side is a valid/ready
// drain port. The collector uses the slave modport, the source/sink the master.
interface gc_stream_collector_if #(
  parameter int S = 8,
  parameter int K = 128
);
  logic [2:0]   tag;
  logic [S-1:0] cid;
  logic [S-1:0] index0;
  logic [S-1:0] index1;
  logic [K-1:0] data0;
  logic [K-1:0] data1;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_region;
  logic         out_last;
  logic [K-1:0] out_data;

  modport master (
    output tag, cid, index0, index1, data0, data1, out_ready,
    input  out_valid, out_region, out_last, out_data
  );

  modport slave (
    input  tag, cid, index0, index1, data0, data1, out_ready,
    output out_valid, out_region, out_last, out_data
  );
endinterface

// File: rtl/gc_stream_collector.sv
// Garbled-circuit output stream collector.
// Decodes tagged beats into label / key / table / mask stores while
// collecting, then drains every store in a fixed order to the host link
// once the terminating cycle id arrives.
module gc_stream_collector #(
  parameter int S         = 8,
  parameter int K         = 128,
  parameter int CC        = 2,
  parameter int INIT_SIZE = 4,
  parameter int IN_SIZE   = 8,
  parameter int AND_GATES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  gc_stream_collector_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LBL_N    = INIT_SIZE + CC * IN_SIZE + 2;
  localparam int TBL_N    = 2 * CC * AND_GATES;
  localparam int KEY_BASE = LBL_N;
  localparam int TBL_BASE = LBL_N + 2;
  localparam int MSK_BASE = TBL_BASE + TBL_N;
  localparam int TOTAL    = MSK_BASE + CC;
  // Address math is widened so cid*scale + index can never wrap.
  localparam int AW       = 2 * S + 4;
  localparam int PW       = $clog2(TOTAL + 1);
  localparam int LW       = (LBL_N > 1) ? $clog2(LBL_N) : 1;
  localparam int TW       = (TBL_N > 1) ? $clog2(TBL_N) : 1;
  localparam int MW       = (CC > 1) ? $clog2(CC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [K-1:0] lbl [LBL_N];
  logic [K-1:0] key [2];
  logic [K-1:0] tbl [TBL_N];
  logic [K-1:0] msk [CC];

  logic [AW-1:0] lbl_a0, lbl_a1, tbl_a0, tbl_a1;
  logic          lbl_ok0, lbl_ok1, tbl_ok0, tbl_ok1, msk_ok;
  logic          end_beat, wr_en;
  logic          is_lbl0, is_lbl1, is_key, is_tbl, is_msk;
  logic          lbl_we0, lbl_we1, key_we, tbl_we0, tbl_we1, msk_we, drop;

  logic [PW-1:0] ptr;
  logic [K-1:0]  rd_data;
  logic [1:0]    rd_region;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status decode.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (end_beat) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (bus.out_valid && bus.out_ready && bus.out_last) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat decode: store addresses, range checks and write enables.
  always_comb begin
    lbl_a0   = AW'(bus.cid) * AW'(IN_SIZE) + AW'(bus.index0);
    lbl_a1   = AW'(bus.cid) * AW'(IN_SIZE) + AW'(bus.index1);
    tbl_a0   = AW'(bus.cid) * AW'(2 * AND_GATES) + AW'(bus.index0);
    tbl_a1   = AW'(bus.cid) * AW'(2 * AND_GATES) + AW'(bus.index1);
    lbl_ok0  = lbl_a0 < AW'(LBL_N);
    lbl_ok1  = lbl_a1 < AW'(LBL_N);
    tbl_ok0  = tbl_a0 < AW'(TBL_N);
    tbl_ok1  = tbl_a1 < AW'(TBL_N);
    msk_ok   = AW'(bus.cid) < AW'(CC);
    end_beat = (state_q == COLLECT) && (AW'(bus.cid) == AW'(CC));
    wr_en    = (state_q == COLLECT) && !end_beat;
    is_lbl0  = bus.tag[2] && bus.tag[0];
    is_lbl1  = bus.tag[2] && bus.tag[1];
    is_key   = bus.tag == 3'b001;
    is_tbl   = bus.tag == 3'b010;
    is_msk   = bus.tag == 3'b011;
    lbl_we0  = wr_en && is_lbl0 && lbl_ok0;
    lbl_we1  = wr_en && is_lbl1 && lbl_ok1;
    key_we   = wr_en && is_key;
    tbl_we0  = wr_en && is_tbl && tbl_ok0;
    tbl_we1  = wr_en && is_tbl && tbl_ok1;
    msk_we   = wr_en && is_msk && msk_ok;
    drop     = wr_en && ((is_lbl0 && !lbl_ok0) || (is_lbl1 && !lbl_ok1) ||
                         (is_tbl && (!tbl_ok0 || !tbl_ok1)) ||
                         (is_msk && !msk_ok));
  end

  // Store writes; port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (lbl_we0) lbl[LW'(lbl_a0)] <= bus.data0;
    if (lbl_we1) lbl[LW'(lbl_a1)] <= bus.data1;
    if (key_we) begin
      key[0] <= bus.data0;
      key[1] <= bus.data1;
    end
    if (tbl_we0) tbl[TW'(tbl_a0)] <= bus.data0;
    if (tbl_we1) tbl[TW'(tbl_a1)] <= bus.data1;
    if (msk_we)  msk[MW'(bus.cid)] <= bus.data0;
  end

  // Sticky drop flag, cleared when a new collection is armed.
  always_ff @(posedge clk) begin
    if (rst)                                                 err <= 1'b0;
    else if (start && (state_q == IDLE || state_q == DONE))  err <= 1'b0;
    else if (drop)                                           err <= 1'b1;
  end

  // Drain read mux: flat pointer mapped onto the four stores in order.
  always_comb begin
    rd_data   = '0;
    rd_region = 2'd0;
    if (ptr < PW'(KEY_BASE)) begin
      rd_region = 2'd0;
      rd_data   = lbl[LW'(ptr)];
    end else if (ptr < PW'(TBL_BASE)) begin
      rd_region = 2'd1;
      rd_data   = key[1'(ptr - PW'(KEY_BASE))];
    end else if (ptr < PW'(MSK_BASE)) begin
      rd_region = 2'd2;
      rd_data   = tbl[TW'(ptr - PW'(TBL_BASE))];
    end else begin
      rd_region = 2'd3;
      rd_data   = msk[MW'(ptr - PW'(MSK_BASE))];
    end
  end

  // Drain output register: loads the next word whenever the slot is empty
  // or being consumed, so outputs hold during stalls and stream at 1/cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.out_region <= 2'd0;
      bus.out_data   <= '0;
      ptr            <= '0;
    end else if (state_q != DRAIN) begin
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
      ptr            <= '0;
    end else if (!bus.out_valid || bus.out_ready) begin
      if (ptr < PW'(TOTAL)) begin
        bus.out_valid  <= 1'b1;
        bus.out_data   <= rd_data;
        bus.out_region <= rd_region;
        bus.out_last   <= (ptr == PW'(TOTAL - 1));
        ptr            <= ptr + 1'b1;
      end else begin
        bus.out_valid  <= 1'b0;
        bus.out_last   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gc_stream_collector.sv
// Randomized bench for gc_stream_collector with a flat reference store
// indexed by drain position.
module tb_gc_stream_collector;
  localparam int S         = 8;
  localparam int K         = 128;
  localparam int CC        = 2;
  localparam int INIT_SIZE = 4;
  localparam int IN_SIZE   = 8;
  localparam int AND_GATES = 16;
  localparam int LBL_N     = INIT_SIZE + CC * IN_SIZE + 2;
  localparam int TBL_N     = 2 * CC * AND_GATES;
  localparam int TOTAL     = LBL_N + 2 + TBL_N + CC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, err;

  gc_stream_collector_if #(.S(S), .K(K)) bus ();

  gc_stream_collector #(
    .S(S), .K(K), .CC(CC), .INIT_SIZE(INIT_SIZE),
    .IN_SIZE(IN_SIZE), .AND_GATES(AND_GATES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [K-1:0] m_word [TOTAL];
  bit           m_known[TOTAL];
  bit           m_err;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic check(input string tg, input logic [K-1:0] got, input logic [K-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tg, got, exp);
    end
  endtask

  function automatic logic [K-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int exp_region(input int pos);
    if (pos < LBL_N)             return 0;
    if (pos < LBL_N + 2)         return 1;
    if (pos < LBL_N + 2 + TBL_N) return 2;
    return 3;
  endfunction

  task automatic mput(input int pos, input logic [K-1:0] d);
    m_word[pos]  = d;
    m_known[pos] = 1'b1;
  endtask

  // Reference decode of one collected beat onto flat drain positions.
  task automatic model_apply(input logic [2:0] t, input int c, input int i0, input int i1,
                             input logic [K-1:0] d0, input logic [K-1:0] d1);
    int a0, a1;
    if (t[2]) begin
      a0 = c * IN_SIZE + i0;
      a1 = c * IN_SIZE + i1;
      if (t[0]) begin
        if (a0 < LBL_N) mput(a0, d0); else m_err = 1'b1;
      end
      if (t[1]) begin
        if (a1 < LBL_N) mput(a1, d1); else m_err = 1'b1;
      end
    end else if (t == 3'b001) begin
      mput(LBL_N, d0);
      mput(LBL_N + 1, d1);
    end else if (t == 3'b010) begin
      a0 = 2 * c * AND_GATES + i0;
      a1 = 2 * c * AND_GATES + i1;
      if (a0 < TBL_N) mput(LBL_N + 2 + a0, d0); else m_err = 1'b1;
      if (a1 < TBL_N) mput(LBL_N + 2 + a1, d1); else m_err = 1'b1;
    end else if (t == 3'b011) begin
      if (c < CC) mput(LBL_N + 2 + TBL_N + c, d0); else m_err = 1'b1;
    end
  endtask

  task automatic beat(input logic [2:0] t, input int c, input int i0, input int i1,
                      input logic [K-1:0] d0, input logic [K-1:0] d1);
    bus.tag    = t;
    bus.cid    = S'(c);
    bus.index0 = S'(i0);
    bus.index1 = S'(i1);
    bus.data0  = d0;
    bus.data1  = d1;
    if (c != CC) model_apply(t, c, i0, i1, d0, d1);
    @(negedge clk);
    bus.tag = 3'b000;
    bus.cid = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    m_err = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rand_beats(input int n, input bit allow_bad);
    logic [2:0] t;
    int c, lim, i0, i1;
    logic [2:0] tags [7] = '{3'b101, 3'b110, 3'b111, 3'b001, 3'b010, 3'b011, 3'b000};
    for (int n_i = 0; n_i < n; n_i++) begin
      t = tags[$urandom_range(0, 6)];
      if (allow_bad) begin
        c  = ($urandom_range(0, 3) == 0) ? CC + 1 : $urandom_range(0, CC - 1);
        i0 = $urandom_range(0, 255);
        i1 = ($urandom_range(0, 3) == 0) ? i0 : $urandom_range(0, 40);
      end else begin
        c   = $urandom_range(0, CC - 1);
        lim = t[2] ? (LBL_N - 1 - c * IN_SIZE) : (TBL_N - 1 - 2 * c * AND_GATES);
        i0  = $urandom_range(0, lim);
        i1  = ($urandom_range(0, 3) == 0) ? i0 : $urandom_range(0, lim);
      end
      beat(t, c, i0, i1, rnd(), rnd());
    end
  endtask

  // Drains with a stalling host; abort_after >= 0 asserts rst after that many words.
  task automatic drain(input int abort_after, input bit scripted);
    int cnt = 0, cyc = 0, vcyc = 0;
    bit fin = 1'b0, rdy, stalled = 1'b0;
    logic [K-1:0] held;
    int pat [4] = '{1, 0, 0, 1};
    check("valid_delay", bus.out_valid, 0);
    check("busy_drain", busy, 1);
    while (!fin && cyc < 3000) begin
      if (bus.out_valid) begin
        if (stalled) check("hold_data", bus.out_data, held);
        if (cnt < TOTAL) begin
          check($sformatf("region@%0d", cnt), bus.out_region, exp_region(cnt));
          check($sformatf("last@%0d", cnt), bus.out_last, cnt == TOTAL - 1);
          if (m_known[cnt]) check($sformatf("data@%0d", cnt), bus.out_data, m_word[cnt]);
        end
        rdy = (scripted && vcyc < 4) ? pat[vcyc][0] : 1'($urandom_range(0, 1));
        vcyc++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      bus.out_ready = rdy;
      stalled = bus.out_valid && !rdy;
      held    = bus.out_data;
      if (bus.out_valid && rdy) begin
        cnt++;
        if (cnt == TOTAL) fin = 1'b1;
      end
      if (abort_after >= 0 && cnt >= abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_err = 1'b0;
        bus.out_ready = 1'b0;
        check("abort_valid", bus.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("word_count", cnt, TOTAL);
    check("done_after_last", done, 1);
    check("busy_after_last", busy, 0);
    check("valid_after_last", bus.out_valid, 0);
  endtask

  initial begin
    logic [K-1:0] a, x, y, p, q, mm;
    bus.tag = '0; bus.cid = '0; bus.index0 = '0; bus.index1 = '0;
    bus.data0 = '0; bus.data1 = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < TOTAL; i++) m_known[i] = 1'b0;
    m_err = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_region", bus.out_region, 0);
    check("rst_data", bus.out_data, 0);

    // Stream 1: fill every store, then directed and random beats.
    do_start();
    check("busy_collect", busy, 1);
    for (int i = 0; i < LBL_N; i += 2) beat(3'b111, 0, i, i + 1, rnd(), rnd());
    beat(3'b001, 0, 0, 0, rnd(), rnd());
    for (int i = 0; i < TBL_N; i += 2) beat(3'b010, 0, i, i + 1, rnd(), rnd());
    for (int c = 0; c < CC; c++) beat(3'b011, c, 0, 0, rnd(), rnd());
    rand_beats(20, 1'b0);
    a = rnd(); x = rnd(); y = rnd(); p = rnd(); q = rnd();
    beat(3'b101, 0, 3, 0, a, rnd());
    beat(3'b111, 0, 2, 2, x, y);
    check("err_same_addr", err, m_err);
    check("err_clean", err, 0);
    beat(3'b010, 1, 4, 5, p, q);
    beat(3'b110, 0, 0, 200, rnd(), rnd());
    check("err_dropped", err, m_err);
    beat(3'($urandom_range(0, 7)), CC, 0, 0, rnd(), rnd());
    drain(-1, 1'b1);
    check("err_sticky", err, m_err);

    // Stream 2: restart from DONE, include dropped writes, reset mid-drain.
    do_start();
    check("err_cleared", err, 0);
    rand_beats(30, 1'b1);
    check("err_stream2", err, m_err);
    beat(3'b000, CC, 0, 0, rnd(), rnd());
    drain(10, 1'b0);

    // Stream 3: full stream after reset, mask for the last cycle drains last.
    do_start();
    rand_beats(25, 1'b0);
    mm = rnd();
    beat(3'b011, 1, 0, 0, mm, rnd());
    check("err_stream3", err, m_err);
    beat(3'b000, CC, 0, 0, rnd(), rnd());
    drain(-1, 1'b0);
    check("final_mask_model", m_word[TOTAL - 1], mm);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
